// File: rtl/regfile_write_arbiter_pkg.sv
// ============================================================================
// Module : regfile_write_arbiter_pkg
// Brief  : Shared constants and helpers for the register-file write arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Writeback requester slots on the shared port
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // Round-robin successor of a granted index
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; the priority pointer is held
//          by the parent.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // Scan from the pointer upward, wrapping, and take the first requester
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module : regfile_write_arbiter
// Brief  : Round-robin share of the register-file write port plus a
//          pending-write scoreboard for decode hazard checks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                  i_pend_set_valid,
    input  logic [ADDR_W-1:0]     i_pend_set_reg,
    output logic [ADDR_W-1:0]     o_write_reg,
    output logic [DATA_W-1:0]     o_write_data,
    output logic                  o_reg_write,
    output logic [NUM_REGS-1:0]   o_pending_mask
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]   r_write_reg;
    logic [DATA_W-1:0]   r_write_data;
    logic                r_reg_write;
    logic [NUM_REGS-1:0] r_mask;

    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic [ADDR_W-1:0]   w_sel_reg;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_nonzero;
    logic [NUM_REGS-1:0] w_mask_next;

    // No grants are offered while reset is held
    assign w_req = rst ? '0 : i_req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign o_req_ready = w_grant;
    assign w_any       = |w_grant;

    always_comb begin
        w_sel_reg  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_reg  = i_req_reg[i*ADDR_W +: ADDR_W];
                w_sel_data = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_nonzero = (w_sel_reg != ADDR_W'(ZERO_REG));

    // Clear is applied before set so a same-edge reissue keeps the bit high
    always_comb begin
        w_mask_next = r_mask;
        if (r_reg_write) begin
            w_mask_next[r_write_reg] = 1'b0;
        end
        if (i_pend_set_valid && (i_pend_set_reg != ADDR_W'(ZERO_REG))) begin
            w_mask_next[i_pend_set_reg] = 1'b1;
        end
        w_mask_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_reg_write  <= 1'b0;
            r_mask       <= '0;
        end else begin
            r_mask      <= w_mask_next;
            r_reg_write <= w_any && w_sel_nonzero;
            if (w_any) begin
                r_ptr <= IDX_W'(rr_next(int'(w_idx), NUM_REQ));
            end
            // A consumed register-0 request leaves the port outputs untouched
            if (w_any && w_sel_nonzero) begin
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
            end
        end
    end

    assign o_write_reg    = r_write_reg;
    assign o_write_data   = r_write_data;
    assign o_reg_write    = r_reg_write;
    assign o_pending_mask = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module : tb_regfile_write_arbiter
// Brief  : Self-checking bench for regfile_write_arbiter against a
//          behavioural model of arbitration, write port and scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_reg;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            pend_set_valid;
    logic [AW-1:0]   pend_set_reg;
    logic [AW-1:0]   write_reg;
    logic [DW-1:0]   write_data;
    logic            reg_write;
    logic [31:0]     pending_mask;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_ptr;
    logic [31:0] m_mask;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid      (req_valid),
        .i_req_reg        (req_reg),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .i_pend_set_valid (pend_set_valid),
        .i_pend_set_reg   (pend_set_reg),
        .o_write_reg      (write_reg),
        .o_write_data     (write_data),
        .o_reg_write      (reg_write),
        .o_pending_mask   (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant();
        int i;
        if (rst) return -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        logic [N-1:0] one;
        one = 1;
        g = model_grant();
        return (g >= 0) ? (one << g) : '0;
    endfunction

    task automatic model_clock();
        int g;
        logic [31:0] nm;
        logic [4:0]  r;
        if (rst) begin
            m_ptr = 0; m_mask = 0; m_rw = 0; m_wr = 0; m_wd = 0;
        end else begin
            g  = model_grant();
            nm = m_mask;
            if (m_rw) nm[m_wr] = 1'b0;
            if (pend_set_valid && pend_set_reg != 0) nm[pend_set_reg] = 1'b1;
            m_rw = 1'b0;
            if (g >= 0) begin
                r     = req_reg[g*AW +: AW];
                m_ptr = (g + 1) % N;
                if (r != 0) begin
                    m_rw = 1'b1;
                    m_wr = r;
                    m_wd = req_data[g*DW +: DW];
                end
            end
            m_mask = nm;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_reg[i*AW +: AW]  = r;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid      = '0;
        pend_set_valid = 1'b0;
        pend_set_reg   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        req_valid = 3'b111;
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready);
        end
        step();
        step();
        n_checks++;
        if (reg_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_reg_write: got %b want 0", reg_write);
        end
        n_checks++;
        if (write_reg !== 5'd0 || write_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_write_port: got reg %0d data %h want 0/0", write_reg, write_data);
        end
        n_checks++;
        if (pending_mask !== 32'd0) begin
            n_fail++; $display("FAIL reset_mask: got %h want 0", pending_mask);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL single_ready: got %b want 001", req_ready);
        end
        step();
        req_valid = '0;
        n_checks++;
        if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_write: got we %b reg %0d data %h want 1/5/deadbeef",
                               reg_write, write_reg, write_data);
        end
        step();
        n_checks++;
        if (reg_write !== 1'b0) begin
            n_fail++; $display("FAIL single_we_drop: got %b want 0", reg_write);
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        logic [N-1:0] one;
        one = 1;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'h1000_0000 + i);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if (req_ready !== (one << order[c])) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, one << order[c]);
            end
            step();
            n_checks++;
            if (reg_write !== 1'b1 || write_reg !== 5'(order[c] + 1)) begin
                n_fail++; $display("FAIL rr_write_reg[%0d]: got we %b reg %0d want 1/%0d",
                                   c, reg_write, write_reg, order[c] + 1);
            end
        end
        idle();
        step();
    endtask

    task automatic test_zero_reg();
        do_reset();
        pend_set_valid = 1'b1;
        pend_set_reg   = 5'd3;
        step();
        pend_set_valid = 1'b0;
        set_req(1, 5'd0, 32'hCAFE0001);
        req_valid = 3'b010;
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_fail++; $display("FAIL zero_ready: got %b want 010", req_ready);
        end
        step();
        req_valid = '0;
        n_checks++;
        if (reg_write !== 1'b0 || write_reg !== 5'd0) begin
            n_fail++; $display("FAIL zero_no_write: got we %b reg %0d want 0/0", reg_write, write_reg);
        end
        n_checks++;
        if (pending_mask !== 32'h0000_0008) begin
            n_fail++; $display("FAIL zero_mask: got %h want 00000008", pending_mask);
        end
        for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), 32'h2000_0000 + i);
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b100) begin
            n_fail++; $display("FAIL zero_ptr_advance: got %b want 100", req_ready);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_scoreboard();
        do_reset();
        pend_set_valid = 1'b1;
        pend_set_reg   = 5'd7;
        step();
        pend_set_valid = 1'b0;
        n_checks++;
        if (pending_mask !== 32'h80) begin
            n_fail++; $display("FAIL sb_set: got %h want 00000080", pending_mask);
        end
        set_req(0, 5'd7, 32'h7777_7777);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        n_checks++;
        if (reg_write !== 1'b1 || pending_mask !== 32'h80) begin
            n_fail++; $display("FAIL sb_during_write: got we %b mask %h want 1/00000080", reg_write, pending_mask);
        end
        step();
        n_checks++;
        if (pending_mask !== 32'h0) begin
            n_fail++; $display("FAIL sb_clear: got %h want 0", pending_mask);
        end
        pend_set_valid = 1'b1;
        pend_set_reg   = 5'd0;
        step();
        pend_set_valid = 1'b0;
        n_checks++;
        if (pending_mask !== 32'h0) begin
            n_fail++; $display("FAIL sb_reg0_ignored: got %h want 0", pending_mask);
        end
    endtask

    task automatic test_collision();
        do_reset();
        pend_set_valid = 1'b1;
        pend_set_reg   = 5'd9;
        step();
        pend_set_valid = 1'b0;
        set_req(0, 5'd9, 32'h9999_0000);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        n_checks++;
        if (reg_write !== 1'b1 || write_reg !== 5'd9) begin
            n_fail++; $display("FAIL coll_write: got we %b reg %0d want 1/9", reg_write, write_reg);
        end
        pend_set_valid = 1'b1;
        pend_set_reg   = 5'd9;
        step();
        pend_set_valid = 1'b0;
        n_checks++;
        if (pending_mask !== 32'h200) begin
            n_fail++; $display("FAIL coll_set_wins: got %h want 00000200", pending_mask);
        end
        step();
        n_checks++;
        if (pending_mask !== 32'h200) begin
            n_fail++; $display("FAIL coll_hold: got %h want 00000200", pending_mask);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pend_set_valid = 1'b1;
        pend_set_reg   = 5'd6;
        step();
        pend_set_valid = 1'b0;
        set_req(1, 5'd4, 32'h4444_4444);
        req_valid = 3'b010;
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++; $display("FAIL midrst_ready: got %b want 000", req_ready);
        end
        step();
        rst = 1'b0;
        idle();
        n_checks++;
        if (reg_write !== 1'b0 || pending_mask !== 32'h0) begin
            n_fail++; $display("FAIL midrst_drop: got we %b mask %h want 0/0", reg_write, pending_mask);
        end
        for (int i = 0; i < N; i++) set_req(i, 5'(20 + i), 32'h3000_0000 + i);
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL midrst_ptr: got %b want 001", req_ready);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] exp_ready;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    set_req(i, 5'($urandom_range(31, 0)), $urandom);
                end
            end
            pend_set_valid = ($urandom_range(3, 0) == 0);
            pend_set_reg   = 5'($urandom_range(31, 0));
            rst            = ($urandom_range(59, 0) == 0);
            #1;
            g         = model_grant();
            exp_ready = model_ready();
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
            end
            step();
            if (g >= 0) req_valid[g] = 1'b0;
            n_checks++;
            if (reg_write !== m_rw || write_reg !== m_wr || write_data !== m_wd) begin
                n_fail++; $display("FAIL rand_port[%0d]: got we %b reg %0d data %h want %b/%0d/%h",
                                   c, reg_write, write_reg, write_data, m_rw, m_wr, m_wd);
            end
            n_checks++;
            if (pending_mask !== m_mask) begin
                n_fail++; $display("FAIL rand_mask[%0d]: got %h want %h", c, pending_mask, m_mask);
            end
        end
        rst = 1'b0;
        idle();
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_reg   = '0;
        req_data  = '0;
        m_ptr = 0; m_mask = 0; m_rw = 0; m_wr = 0; m_wd = 0;
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between several writeback sources (ALU result, load result, link/JAL), one grant per cycle, round-robin.
- Drives the register file's Write_Reg / Write_Data / Reg_Write inputs from registers.
- Keeps a 32-bit pending-write scoreboard that decode uses for read-after-write hazard stalls.

Parameters:
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = link).
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- Clock  input  1  single clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- Req_Valid  input  NUM_REQ  per-requester write request.
- Req_Reg  input  NUM_REQ*ADDR_W  destination register; requester i in slice [i*ADDR_W +: ADDR_W].
- Req_Data  input  NUM_REQ*DATA_W  write data; requester i in slice [i*DATA_W +: DATA_W].
- Req_Ready  output  NUM_REQ  one-hot grant, combinational; a request is accepted when Valid && Ready.
- Pend_Set_Valid  input  1  decode issued an instruction that will write Pend_Set_Reg.
- Pend_Set_Reg  input  ADDR_W  destination register being marked pending.
- Write_Reg  output  ADDR_W  register-file write address, registered.
- Write_Data  output  DATA_W  register-file write data, registered.
- Reg_Write  output  1  register-file write enable, registered.
- Pending_Mask  output  32  bit r = 1 means a write to register r is outstanding.

Behaviour:
- Reset (sync): Write_Reg=0, Write_Data=0, Reg_Write=0, Pending_Mask=0, priority pointer=0. Req_Ready is 0 for every requester while Reset is high.
- Arbitration is round-robin. The requester at the pointer has top priority, then pointer+1, and so on modulo NUM_REQ. Exactly one Req_Ready bit is high when any Req_Valid bit is high; otherwise all are 0.
- The pointer moves to (granted index + 1) mod NUM_REQ only on a grant. With no valid requests the pointer holds.
- Latency: a grant in cycle N produces Reg_Write=1, Write_Reg and Write_Data from the granted requester in cycle N+1. The register file captures the value on the next posedge. With no grant, Reg_Write=0 in cycle N+1 and Write_Reg/Write_Data hold their previous values.
- Throughput: one write per cycle. A requester that is not granted must hold Valid, Reg and Data stable until it is granted.
- Register 0: a request with Req_Reg=0 is still granted and consumed. Reg_Write stays 0 for that slot, the pointer still advances, and the scoreboard is untouched.
- Scoreboard set: Pend_Set_Valid with Pend_Set_Reg≠0 sets the bit at the posedge. A set for register 0 is ignored, so bit 0 is always 0.
- Scoreboard clear: the bit for Write_Reg clears in the cycle after Reg_Write=1, i.e. at the posedge that ends the Reg_Write cycle.
- Set and clear of the same register on the same posedge: set wins and the bit stays 1 (a newer writer has issued).
- Set of a bit already at 1: it stays 1. The scoreboard is a single bit per register, not a counter.
- Reset asserted mid-operation: an in-flight granted write is dropped (Reg_Write=0 next cycle). The scoreboard clears and the pointer returns to 0.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG=0.
  - Requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_LINK=2.
- One natural sub-module: rr_arbiter (parameterised NUM_REQ). Inputs: request vector and pointer. Outputs: one-hot grant and encoded index. It is purely combinational; the pointer register lives in the parent.
- Scoreboard and output registers stay in regfile_write_arbiter.

Test Plan:
- Single request: Reset 2 cycles, then Req_Valid=001, Req_Reg[0]=5, Req_Data[0]=0xDEADBEEF → Req_Ready=001 the same cycle; next cycle Reg_Write=1, Write_Reg=5, Write_Data=0xDEADBEEF; the cycle after, Reg_Write=0.
- Round-robin fairness: all three Valid held 6 cycles, distinct regs 1/2/3 → grant order 0,1,2,0,1,2; Write_Reg sequence 1,2,3,1,2,3 one cycle delayed.
- Zero register: Req_Valid=010, Req_Reg[1]=0 → Req_Ready=010, Reg_Write stays 0, Pending_Mask unchanged; the next simultaneous 3-way request is granted to requester 2 first.
- Scoreboard lifecycle: Pend_Set reg 7 → Pending_Mask=0x80. ALU writes reg 7 → mask 0x80 during the Reg_Write cycle, 0x0 after. Pend_Set reg 0 → mask stays 0.
- Set/clear collision: reg 9 pending, its write has Reg_Write=1 in cycle N, and Pend_Set_Reg=9 in the same cycle N → Pending_Mask bit 9 remains 1 afterwards.
- Mid-operation reset: grant requester 1 (reg 4) and assert Reset the same cycle → next cycle Reg_Write=0, Pending_Mask=0; after release the first 3-way request is granted to requester 0.
